seq_right_shifter: RTL and testbench
====================================

// Module: seq_right_shifter
// PURPOSE
//  Multi-cycle right shifter, logical or arithmetic; companion to the combinational left shifter in the ALU.
//  Shifts by STEP bits per clock under a start/done handshake.
//  Shift-amount semantics match the left shifter: b[4:0] selects the shift; any bit of b[31:5] set means out-of-range.
//  Sits beside the ALU; the regbank controller issues start and stalls until done.
// PARAMETERS
//  WIDTH  32  operand/result width; fixed at 32 for this ALU
//  STEP   1   bits shifted per cycle; must be 1, 2, 4, 8 or 16
// PORTS
//  clk    in   1      rising-edge clock
//  rst_n  in   1      reset, asynchronous assert, active-low
//  start  in   1      request; sampled only when busy=0
//  a      in   32     operand to shift
//  b      in   32     shift amount; b[31:5]!=0 means out-of-range
//  arith  in   1      1 = arithmetic (sign-fill with a[31]); 0 = logical (zero-fill)
//  busy   out  1      high from the cycle after start is accepted until done
//  done   out  1      one-cycle pulse when ans is valid
//  ans    out  32     result; held stable from done until the next accepted start
// BEHAVIOUR
//  Reset (rst_n=0, any time, including mid-operation):
//   - state=IDLE; busy=0, done=0, ans=0; internal count and operand cleared.
//  FSM: IDLE -> SHIFT -> DONE -> IDLE.
//   - IDLE: start=1 latches a, arith, fill=arith&a[31], and k.
//     k = b[4:0] if b[31:5]==0, else k = WIDTH (out-of-range).
//     Next state is SHIFT; busy=1.
//   - SHIFT: each cycle, shift the working register right by min(STEP, rem) bits, inserting fill bits at the MSB.
//     rem decrements by the same amount. When rem==0 at cycle start, go to DONE without shifting.
//   - DONE: ans <= working register; done=1 for exactly this cycle; busy=0.
//     Next state is IDLE. start asserted in the DONE cycle is ignored.
//  Latency: done pulses ceil(k/STEP)+1 cycles after the accepting clock edge. k=0 gives 1 cycle and ans=a.
//  Out-of-range result: all bits = fill, i.e. 0x0000_0000 (logical) or 32 copies of a[31] (arithmetic).
//  start while busy=1 is ignored; no queueing and no error flag.
//  a, b and arith may change freely after acceptance; only latched copies are used.
//  ans changes only in the DONE cycle or on reset.
// CONFIGURATION
//  Macro SHIFT_BYPASS_EN:
//   - Defined: when k==0 or b is out-of-range, go directly from IDLE to DONE.
//     The working register is preloaded with a (k=0) or all-fill (out-of-range).
//     done pulses exactly 1 cycle after acceptance.
//   - Undefined: these cases iterate normally. Out-of-range costs WIDTH/STEP+1 cycles.
//   - Results are identical in both builds; only latency differs.
// TESTING
//  1. WIDTH=32, STEP=1: a=32'h8000_0000, b=4, arith=0 -> done 5 cycles after start, ans=32'h0800_0000.
//  2. Same operands with arith=1 -> done at 5 cycles, ans=32'hF800_0000.
//  3. a=32'h8000_0001, b=32'h20, arith=1 -> ans=32'hFFFF_FFFF.
//     done at 33 cycles (macro undefined) or 1 cycle (SHIFT_BYPASS_EN).
//     Repeat with arith=0 -> ans=0.
//  4. a=32'h1234_5678, b=0 -> done at 1 cycle, ans=32'h1234_5678.
//     STEP=4, a=32'hF000_0000, b=9, arith=0 -> done at 4 cycles, ans=32'h0078_0000.
//  5. Start a=32'hFFFF_FFFF, b=31; pulse start again at cycle 3 with b=1 -> second start ignored.
//     Result: ans=32'h0000_0001 at cycle 32, then the bench issues a new start.
//  6. Start b=20; drive rst_n=0 asynchronously at cycle 7 -> busy=0, done=0, ans=0 immediately.
//     After release, a=32'h0000_0100, b=8 -> ans=32'h0000_0001.

Source files
------------

// File: rtl/seq_right_shifter.sv
// Multi-cycle logical/arithmetic right shifter that moves STEP bits per clock under a start/done handshake.
// Optional build macro SHIFT_BYPASS_EN preloads the result for zero and out-of-range shifts.
module seq_right_shifter #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             arith,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] ans
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state;
  logic [WIDTH-1:0]  work;
  logic [CW-1:0]     rem;
  logic              fill;

  logic              outOfRange;
  logic [CW-1:0]     kIn;
  logic              fillIn;
  logic [CW-1:0]     amt;
  logic signed [WIDTH:0] extWork;
  logic [WIDTH:0]    shifted;

  // Any bit above b[4:0] forces a full-width shift, matching the left shifter.
  assign outOfRange = |b[WIDTH-1:5];
  assign kIn        = outOfRange ? CW'(WIDTH) : CW'(b[4:0]);
  assign fillIn     = arith & a[WIDTH-1];

  // The fill bit rides above the working register so a signed shift inserts it at the MSB.
  assign amt     = (rem < CW'(STEP)) ? rem : CW'(STEP);
  assign extWork = {fill, work};
  assign shifted = extWork >>> amt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      work  <= '0;
      rem   <= '0;
      fill  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      ans   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            fill  <= fillIn;
            busy  <= 1'b1;
            state <= SHIFT;
`ifdef SHIFT_BYPASS_EN
            // Trivial shifts land the final value now, so SHIFT finishes on its first cycle.
            if (outOfRange || kIn == '0) begin
              work <= outOfRange ? {WIDTH{fillIn}} : a;
              rem  <= '0;
            end else begin
              work <= a;
              rem  <= kIn;
            end
`else
            work <= a;
            rem  <= kIn;
`endif
          end
        end
        SHIFT: begin
          if (rem == '0) begin
            ans   <= work;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end else begin
            work <= shifted[WIDTH-1:0];
            rem  <= rem - amt;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_right_shifter.sv
// Directed bench for seq_right_shifter: vector table on STEP=1 and STEP=4 instances plus handshake and reset sequences.
module tb_seq_right_shifter;

`ifdef SHIFT_BYPASS_EN
  localparam int OOR1 = 1;
  localparam int OOR4 = 1;
`else
  localparam int OOR1 = 33;
  localparam int OOR4 = 9;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start1 = 1'b0;
  logic        start4 = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        arith = 1'b0;
  logic        busy1, done1, busy4, done4;
  logic [31:0] ans1, ans4;

  int checkCount = 0;
  int passCount  = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        arith;
    logic [31:0] expAns;
    int          expLat;
    bit          step4;
  } vec_t;

  vec_t vecs[$];

  seq_right_shifter #(.WIDTH(32), .STEP(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a), .b(b), .arith(arith),
    .busy(busy1), .done(done1), .ans(ans1)
  );

  seq_right_shifter #(.WIDTH(32), .STEP(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a), .b(b), .arith(arith),
    .busy(busy4), .done(done4), .ans(ans4)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  task automatic waitDone(input bit sel, output int cycles);
    cycles = 0;
    do begin
      @(posedge clk);
      #1;
      cycles++;
    end while (!(sel ? done4 : done1) && cycles < 200);
    if (!(sel ? done4 : done1)) $display("[TB] FAIL done_timeout: got no done after %0d cycles, expected a pulse", cycles);
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    int cycles;
    @(negedge clk);
    a = v.a; b = v.b; arith = v.arith;
    if (v.step4) start4 = 1'b1; else start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0; start4 = 1'b0;
    a = $urandom; b = $urandom; arith = ~arith;
    checkOutput($sformatf("busy_after_start[%0d]", idx), {31'b0, v.step4 ? busy4 : busy1}, 32'd1);
    waitDone(v.step4, cycles);
    checkOutput($sformatf("latency[%0d]", idx), cycles, v.expLat);
    checkOutput($sformatf("ans[%0d]", idx), v.step4 ? ans4 : ans1, v.expAns);
    checkOutput($sformatf("busy_at_done[%0d]", idx), {31'b0, v.step4 ? busy4 : busy1}, 32'd0);
    @(posedge clk);
    #1;
    checkOutput($sformatf("done_one_cycle[%0d]", idx), {31'b0, v.step4 ? done4 : done1}, 32'd0);
    checkOutput($sformatf("ans_held[%0d]", idx), v.step4 ? ans4 : ans1, v.expAns);
  endtask

  initial begin
    int cycles;
    vec_t v;

    vecs.push_back('{32'h8000_0000, 32'd4,      1'b0, 32'h0800_0000, 5,    1'b0});
    vecs.push_back('{32'h8000_0000, 32'd4,      1'b1, 32'hF800_0000, 5,    1'b0});
    vecs.push_back('{32'h8000_0001, 32'h20,     1'b1, 32'hFFFF_FFFF, OOR1, 1'b0});
    vecs.push_back('{32'h8000_0001, 32'h20,     1'b0, 32'h0000_0000, OOR1, 1'b0});
    vecs.push_back('{32'h1234_5678, 32'd0,      1'b0, 32'h1234_5678, 1,    1'b0});
    vecs.push_back('{32'h1234_5678, 32'd0,      1'b1, 32'h1234_5678, 1,    1'b0});
    vecs.push_back('{32'hF0F0_F0F0, 32'd8,      1'b1, 32'hFFF0_F0F0, 9,    1'b0});
    vecs.push_back('{32'hF0F0_F0F0, 32'd31,     1'b0, 32'h0000_0001, 32,   1'b0});
    vecs.push_back('{32'h7FFF_FFFF, 32'd31,     1'b1, 32'h0000_0000, 32,   1'b0});
    vecs.push_back('{32'h1234_5678, 32'h100,    1'b1, 32'h0000_0000, OOR1, 1'b0});
    vecs.push_back('{32'h8000_0000, 32'h24,     1'b1, 32'hFFFF_FFFF, OOR1, 1'b0});
    vecs.push_back('{32'hF000_0000, 32'd9,      1'b0, 32'h0078_0000, 4,    1'b1});
    vecs.push_back('{32'h8000_0000, 32'd31,     1'b1, 32'hFFFF_FFFF, 9,    1'b1});
    vecs.push_back('{32'h8000_0000, 32'd32,     1'b1, 32'hFFFF_FFFF, OOR4, 1'b1});
    vecs.push_back('{32'h1234_5678, 32'd0,      1'b0, 32'h1234_5678, 1,    1'b1});

    // Reset state
    #12;
    checkOutput("reset_busy1", {31'b0, busy1}, 32'd0);
    checkOutput("reset_done1", {31'b0, done1}, 32'd0);
    checkOutput("reset_ans1", ans1, 32'd0);
    checkOutput("reset_ans4", ans4, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) applyStimulus(vecs[i], i);

    // Start while busy is ignored; start in the DONE cycle is ignored too
    @(negedge clk);
    a = 32'hFFFF_FFFF; b = 32'd31; arith = 1'b0; start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    cycles = 0;
    do begin
      @(posedge clk);
      #1;
      cycles++;
      if (cycles == 2) begin b = 32'd1; start1 = 1'b1; end
      if (cycles == 3) start1 = 1'b0;
    end while (!done1 && cycles < 200);
    checkOutput("busy_ignore_latency", cycles, 32);
    checkOutput("busy_ignore_ans", ans1, 32'h0000_0001);
    a = 32'h0000_0100; b = 32'd8; arith = 1'b0; start1 = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("done_cycle_start_ignored", {31'b0, busy1}, 32'd0);
    @(posedge clk);
    #1;
    start1 = 1'b0;
    checkOutput("restart_accepted", {31'b0, busy1}, 32'd1);
    waitDone(1'b0, cycles);
    checkOutput("restart_latency", cycles, 9);
    checkOutput("restart_ans", ans1, 32'h0000_0001);

    // Asynchronous reset mid-operation
    @(negedge clk);
    a = 32'hFFFF_FFFF; b = 32'd20; arith = 1'b0; start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_busy", {31'b0, busy1}, 32'd0);
    checkOutput("async_reset_done", {31'b0, done1}, 32'd0);
    checkOutput("async_reset_ans", ans1, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    v = '{32'h0000_0100, 32'd8, 1'b0, 32'h0000_0001, 9, 1'b0};
    applyStimulus(v, 99);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
